lsq_dcache_scheduler: RTL and testbench

// - Schedules the single D-cache port between the load-queue head and the committed store-queue head.
// - Sits in the memory stage, ahead of the D-cache and the mem-stage completion logic.
// - Chooses READ or WRITE, sequences one access at a time and reports completion as pop/done pulses.
// - Discards in-flight load data on a pipeline flush.

---
 rtl/lsq_dcache_scheduler.sv | 163 ++++++++++++++++
 tb/tb_lsq_dcache_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lsq_dcache_scheduler.sv
// Arbitrates the single D-cache port between the load-queue head and the committed
// store-queue head, one access in flight at a time, with flush-aware load retirement.
module lsq_dcache_scheduler #(
  parameter int unsigned ID_W         = 6,
  parameter int unsigned SQ_W         = 3,
  parameter int unsigned SQ_HIGH      = 6,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_req_valid,
  input  logic [ID_W-1:0] ld_req_id,
  input  logic            ld_bypass,
  input  logic            st_req_valid,
  input  logic [ID_W-1:0] st_req_id,
  input  logic [SQ_W:0]   sq_count,
  input  logic            flush,
  input  logic            dc_ready,
  input  logic            dc_done,
  output logic            dc_req_valid,
  output logic            dc_req_write,
  output logic [ID_W-1:0] dc_req_id,
  output logic            ld_pop,
  output logic            ld_done_valid,
  output logic [ID_W-1:0] ld_done_id,
  output logic            st_pop,
  output logic            st_done_valid,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SQ_W:0]    SqHigh    = SQ_HIGH[SQ_W:0];
  localparam logic [CNT_W-1:0] StarveMax = STARVE_LIMIT[CNT_W-1:0];

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStore,
    StFlushWait
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic store_pick;
  logic load_pick;
  logic idle_grant_ok;
  logic store_accept;
  logic load_grant;

  // Store wins when the queue is filling up, when there is no load, or when loads
  // have hogged the port for STARVE_LIMIT grants in a row.
  assign store_pick = st_req_valid &&
                      (sq_count >= SqHigh || !ld_req_valid || starve_q == StarveMax);
  assign load_pick  = ld_req_valid && !store_pick;

  assign idle_grant_ok = !rst && state_q == StIdle && !flush;
  assign store_accept  = idle_grant_ok && store_pick && dc_ready;
  assign load_grant    = idle_grant_ok && load_pick && (ld_bypass || dc_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      id_q     <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (store_accept || !st_req_valid) begin
      starve_d = '0;
    end else if (load_grant && starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    dc_req_valid  = 1'b0;
    dc_req_write  = 1'b0;
    dc_req_id     = '0;
    ld_pop        = 1'b0;
    ld_done_valid = 1'b0;
    ld_done_id    = '0;
    st_pop        = 1'b0;
    st_done_valid = 1'b0;
    busy          = 1'b0;

    if (!rst) begin
      busy = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (!flush) begin
            if (store_pick) begin
              if (dc_ready) begin
                dc_req_valid = 1'b1;
                dc_req_write = 1'b1;
                dc_req_id    = st_req_id;
                id_d         = st_req_id;
                state_d      = StStore;
              end
            end else if (load_pick) begin
              if (ld_bypass) begin
                // Fully forwarded: retire without touching the cache.
                ld_pop        = 1'b1;
                ld_done_valid = 1'b1;
                ld_done_id    = ld_req_id;
              end else if (dc_ready) begin
                dc_req_valid = 1'b1;
                dc_req_id    = ld_req_id;
                id_d         = ld_req_id;
                state_d      = StLoad;
              end
            end
          end
        end
        StLoad: begin
          if (dc_done) begin
            state_d = StIdle;
            if (!flush) begin
              ld_pop        = 1'b1;
              ld_done_valid = 1'b1;
              ld_done_id    = id_q;
            end
          end else if (flush) begin
            state_d = StFlushWait;
          end
        end
        StStore: begin
          // Committed stores are architectural, so flush has no effect here.
          if (dc_done) begin
            st_pop        = 1'b1;
            st_done_valid = 1'b1;
            state_d       = StIdle;
          end
        end
        StFlushWait: begin
          if (dc_done) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  a_req_needs_ready: assert property (@(posedge clk) disable iff (rst)
    dc_req_valid |-> dc_ready);
  a_ld_pop_with_done: assert property (@(posedge clk) disable iff (rst)
    ld_pop == ld_done_valid);
  a_st_pop_with_done: assert property (@(posedge clk) disable iff (rst)
    st_pop == st_done_valid);
  a_one_event: assert property (@(posedge clk) disable iff (rst)
    $onehot0({dc_req_valid, ld_done_valid, st_done_valid}));

endmodule

// File: tb/tb_lsq_dcache_scheduler.sv
// Randomized scoreboard bench: the driver runs an abstract access model and queues the
// expected events; a negedge monitor pops and compares them against the DUT.
module tb_lsq_dcache_scheduler;

  localparam int ID_W = 6;
  localparam int SQ_W = 3;
  localparam int SQ_HIGH = 6;
  localparam int STARVE_LIMIT = 4;

  logic            clk;
  logic            rst;
  logic            ld_req_valid;
  logic [ID_W-1:0] ld_req_id;
  logic            ld_bypass;
  logic            st_req_valid;
  logic [ID_W-1:0] st_req_id;
  logic [SQ_W:0]   sq_count;
  logic            flush;
  logic            dc_ready;
  logic            dc_done;
  logic            dc_req_valid;
  logic            dc_req_write;
  logic [ID_W-1:0] dc_req_id;
  logic            ld_pop;
  logic            ld_done_valid;
  logic [ID_W-1:0] ld_done_id;
  logic            st_pop;
  logic            st_done_valid;
  logic            busy;

  lsq_dcache_scheduler #(
    .ID_W(ID_W), .SQ_W(SQ_W), .SQ_HIGH(SQ_HIGH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_req_valid(ld_req_valid), .ld_req_id(ld_req_id), .ld_bypass(ld_bypass),
    .st_req_valid(st_req_valid), .st_req_id(st_req_id), .sq_count(sq_count),
    .flush(flush), .dc_ready(dc_ready), .dc_done(dc_done),
    .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write), .dc_req_id(dc_req_id),
    .ld_pop(ld_pop), .ld_done_valid(ld_done_valid), .ld_done_id(ld_done_id),
    .st_pop(st_pop), .st_done_valid(st_done_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            w;
    logic [ID_W-1:0] id;
  } req_t;

  // Expectations, one entry per cycle at most for events, exactly one for busy.
  req_t            req_q[$];
  logic [ID_W-1:0] ldd_q[$];
  bit              std_q[$];
  bit              busy_q[$];

  int checks = 0;
  int failures = 0;

  // Abstract model: is an access outstanding, what kind, and was it orphaned by a flush.
  bit              m_busy;
  bit              m_store;
  bit              m_disc;
  logic [ID_W-1:0] m_id;
  int              m_starve;
  // Behavioural D-cache: cycles left until it raises dc_done.
  bit              c_active;
  int              c_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit   eb;
    bit   exp_req, exp_ld, exp_st;
    req_t r;
    logic [ID_W-1:0] lid;
    if (busy_q.size() != 0) begin
      eb = busy_q.pop_front();
      chk("busy", {31'd0, busy}, {31'd0, eb});
      exp_req = req_q.size() != 0;
      exp_ld  = ldd_q.size() != 0;
      exp_st  = std_q.size() != 0;
      chk("dc_req_valid", {31'd0, dc_req_valid}, {31'd0, exp_req});
      if (exp_req) begin
        r = req_q.pop_front();
        if (dc_req_valid) begin
          chk("dc_req_write", {31'd0, dc_req_write}, {31'd0, r.w});
          chk("dc_req_id", {26'd0, dc_req_id}, {26'd0, r.id});
        end
      end
      chk("ld_done_valid", {31'd0, ld_done_valid}, {31'd0, exp_ld});
      chk("ld_pop", {31'd0, ld_pop}, {31'd0, exp_ld});
      if (exp_ld) begin
        lid = ldd_q.pop_front();
        if (ld_done_valid) chk("ld_done_id", {26'd0, ld_done_id}, {26'd0, lid});
      end
      chk("st_done_valid", {31'd0, st_done_valid}, {31'd0, exp_st});
      chk("st_pop", {31'd0, st_pop}, {31'd0, exp_st});
      if (exp_st) void'(std_q.pop_front());
    end
  end

  task automatic start_cache();
    c_active = 1'b1;
    c_wait   = $urandom_range(0, 3);
  endtask

  // Percent knobs for each input; p_rst is per-mille.
  task automatic do_cycle(input int p_ld, input int p_st, input int p_byp, input int p_flush,
                          input int p_rdy, input int p_hisq, input int p_rst);
    bit   sp, lp;
    req_t r;
    @(posedge clk);
    #1;
    rst          = ($urandom % 1000) < p_rst;
    ld_req_valid = ($urandom % 100) < p_ld;
    ld_req_id    = ID_W'($urandom);
    ld_bypass    = ($urandom % 100) < p_byp;
    st_req_valid = ($urandom % 100) < p_st;
    st_req_id    = ID_W'($urandom);
    sq_count     = (($urandom % 100) < p_hisq) ? (SQ_W+1)'($urandom_range(6, 8))
                                               : (SQ_W+1)'($urandom_range(0, 5));
    flush        = ($urandom % 100) < p_flush;
    dc_ready     = ($urandom % 100) < p_rdy;
    dc_done      = c_active ? (c_wait == 0) : (($urandom % 8) == 0);

    if (rst) begin
      busy_q.push_back(1'b0);
      m_busy   = 1'b0;
      m_starve = 0;
      c_active = 1'b0;
    end else begin
      busy_q.push_back(m_busy);
      if (c_active) begin
        if (c_wait == 0) c_active = 1'b0;
        else c_wait--;
      end
      if (!m_busy) begin
        if (!flush) begin
          sp = st_req_valid && (sq_count >= SQ_HIGH || !ld_req_valid ||
                                m_starve == STARVE_LIMIT);
          lp = ld_req_valid && !sp;
          if (sp && dc_ready) begin
            r.w = 1'b1; r.id = st_req_id;
            req_q.push_back(r);
            m_busy = 1'b1; m_store = 1'b1; m_disc = 1'b0;
            m_starve = 0;
            start_cache();
          end else if (lp && (ld_bypass || dc_ready)) begin
            if (ld_bypass) begin
              ldd_q.push_back(ld_req_id);
            end else begin
              r.w = 1'b0; r.id = ld_req_id;
              req_q.push_back(r);
              m_busy = 1'b1; m_store = 1'b0; m_disc = 1'b0; m_id = ld_req_id;
              start_cache();
            end
            if (st_req_valid && m_starve < STARVE_LIMIT) m_starve++;
          end
        end
      end else if (dc_done) begin
        if (m_store) std_q.push_back(1'b1);
        else if (!m_disc && !flush) ldd_q.push_back(m_id);
        m_busy = 1'b0;
      end else if (!m_store && flush) begin
        m_disc = 1'b1;
      end
      if (!st_req_valid) m_starve = 0;
    end
  endtask

  initial begin
    rst = 1'b1; ld_req_valid = 0; ld_req_id = '0; ld_bypass = 0; st_req_valid = 0;
    st_req_id = '0; sq_count = '0; flush = 0; dc_ready = 0; dc_done = 0;
    m_busy = 0; m_store = 0; m_disc = 0; m_id = '0; m_starve = 0;
    c_active = 0; c_wait = 0;
    // Reset phase with requests and cache activity present: all outputs must stay 0.
    for (int i = 0; i < 4; i++) do_cycle(100, 100, 30, 0, 100, 50, 1000);
    for (int i = 0; i < 800; i++) do_cycle(60, 50, 25, 8, 75, 30, 3);
    // Both heads always pending with low occupancy: exercises the starvation limit.
    for (int i = 0; i < 500; i++) do_cycle(100, 100, 40, 0, 90, 0, 0);
    for (int i = 0; i < 500; i++) do_cycle(100, 100, 10, 0, 90, 60, 0);
    for (int i = 0; i < 600; i++) do_cycle(90, 30, 10, 30, 80, 20, 5);
    for (int i = 0; i < 400; i++) do_cycle(80, 80, 20, 5, 10, 30, 2);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 100, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
